// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared constants, width helpers and parameter legality checks
//               for the parametrised serial-pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int c_PAT_W_MIN = 2;
    localparam int c_PAT_W_MAX = 16;
    localparam int c_CNT_W_MIN = 1;
    localparam int c_CNT_W_MAX = 32;

    // Reset values of the detector state and the match counter.
    localparam int c_FILL_RST = 0;
    localparam int c_HIST_RST = 0;
    localparam int c_CNT_RST  = 0;

    // Fill counter must reach PAT_W-1, which always fits in $clog2(PAT_W) bits.
    function automatic int fill_width(input int pat_w);
        return (pat_w < c_PAT_W_MIN) ? 1 : $clog2(pat_w);
    endfunction

    function automatic bit pat_w_legal(input int pat_w);
        return (pat_w >= c_PAT_W_MIN) && (pat_w <= c_PAT_W_MAX);
    endfunction

    function automatic bit cnt_w_legal(input int cnt_w);
        return (cnt_w >= c_CNT_W_MIN) && (cnt_w <= c_CNT_W_MAX);
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_match_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_counter
// Description : Saturating match counter with synchronous clear (clear wins
//               over increment) and asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_W'(c_CNT_RST);
        end else if (i_clr) begin
            r_cnt <= CNT_W'(c_CNT_RST);
        end else if (i_inc && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule : seq_match_counter
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Mealy serial-pattern detector with runtime-loadable pattern,
//               overlapping/non-overlapping modes and an optional saturating
//               match counter built only when SEQ_MATCH_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011,
    parameter int               CNT_W       = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             d_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             d_out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FILL_W      = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(PAT_W - 1);

    if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W=%0d outside 2..16", PAT_W);
    end
    if (!cnt_w_legal(CNT_W)) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W=%0d outside 1..32", CNT_W);
    end

    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;

    logic [PAT_W-1:0]  w_window;
    logic              w_full;
    logic              w_match;

    // Window is the candidate pattern: stored history plus the bit arriving now.
    assign w_window = {r_hist, d_in};
    assign w_full   = (r_fill == c_FILL_FULL);
    assign w_match  = d_valid & ~pat_load & w_full & (w_window == r_pat);
    assign d_out    = w_match & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= DEFAULT_PAT;
            r_hist <= (PAT_W-1)'(c_HIST_RST);
            r_fill <= FILL_W'(c_FILL_RST);
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_hist <= (PAT_W-1)'(c_HIST_RST);
            r_fill <= FILL_W'(c_FILL_RST);
        end else if (d_valid) begin
            if (w_match && !overlap_en) begin
                r_hist <= (PAT_W-1)'(c_HIST_RST);
                r_fill <= FILL_W'(c_FILL_RST);
            end else begin
                r_hist <= w_window[PAT_W-2:0];
                if (!w_full) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end
        end
    end

`ifdef SEQ_MATCH_CNT_EN
    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst   (rst),
        .i_inc (d_out),
        .i_clr (cnt_clr),
        .o_cnt (match_cnt)
    );
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Self-checking bench: directed scenarios plus random stream
//               compared with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
`ifdef SEQ_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             rst        = 1'b0;
    logic             d_in       = 1'b0;
    logic             d_valid    = 1'b0;
    logic             overlap_en = 1'b1;
    logic             pat_load   = 1'b0;
    logic [PAT_W-1:0] pat_in     = '0;
    logic             cnt_clr    = 1'b0;
    logic             d_out;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_W       (PAT_W),
        .DEFAULT_PAT (4'b1011),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .d_valid    (d_valid),
        .overlap_en (overlap_en),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .cnt_clr    (cnt_clr),
        .d_out      (d_out),
        .match_cnt  (match_cnt)
    );

    // Reference model: accepted bits since last clear, current pattern, count.
    bit         m_bits[$];
    logic [3:0] m_pat = 4'b1011;
    int         m_cnt = 0;

    function automatic bit model_match(input bit d);
        logic [3:0] w;
        int n;
        n = m_bits.size();
        if (n < PAT_W - 1) return 1'b0;
        w = {m_bits[n-3], m_bits[n-2], m_bits[n-1], d};
        return w == m_pat;
    endfunction

    function automatic bit model_dout();
        return !rst && d_valid && !pat_load && model_match(d_in);
    endfunction

    function automatic logic [CNT_W-1:0] model_cnt();
        return CNT_EN ? CNT_W'(m_cnt) : '0;
    endfunction

    task automatic model_clock();
        bit hit;
        if (rst) return;
        hit = model_dout();
        if (CNT_EN) begin
            if (cnt_clr) m_cnt = 0;
            else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        if (pat_load) begin
            m_pat = pat_in;
            m_bits.delete();
        end else if (d_valid) begin
            if (hit && !overlap_en) m_bits.delete();
            else begin
                m_bits.push_back(d_in);
                if (m_bits.size() > PAT_W - 1) void'(m_bits.pop_front());
            end
        end
    endtask

    task automatic apply(input logic d, input logic v);
        @(negedge clk);
        d_in = d; d_valid = v; pat_load = 1'b0; cnt_clr = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; d_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_bits.delete(); m_pat = 4'b1011; m_cnt = 0;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1); tick();
        apply(1'b0, 1'b1); tick();
        apply(1'b1, 1'b1); tick();
        @(negedge clk);
        rst = 1'b1; d_in = 1'b1; d_valid = 1'b1;
        #1;
        checks++;
        if (d_out !== 1'b0) begin
            errors++; $display("FAIL reset_dout: got %b expected 0", d_out);
        end
        checks++;
        if (match_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt);
        end
        @(negedge clk);
        rst = 1'b0; d_valid = 1'b0;
        m_bits.delete(); m_pat = 4'b1011; m_cnt = 0;
    endtask

    task automatic run_stream(input string name, input bit ov,
                              input logic [6:0] bits, input logic [6:0] exp);
        do_reset();
        overlap_en = ov;
        for (int i = 6; i >= 0; i--) begin
            apply(bits[i], 1'b1);
            checks++;
            if (d_out !== exp[i]) begin
                errors++;
                $display("FAIL %s bit%0d: d_out %b expected %b", name, 7 - i, d_out, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_overlap();
        run_stream("overlap", 1'b1, 7'b1011011, 7'b0001001);
        apply(1'b0, 1'b0);
        checks++;
        if (match_cnt !== (CNT_EN ? 2'd2 : 2'd0)) begin
            errors++; $display("FAIL overlap_cnt: got %0d expected %0d", match_cnt, CNT_EN ? 2 : 0);
        end
        tick();
    endtask

    task automatic test_nonoverlap();
        run_stream("nonoverlap", 1'b0, 7'b1011011, 7'b0001000);
        apply(1'b0, 1'b0);
        checks++;
        if (match_cnt !== (CNT_EN ? 2'd1 : 2'd0)) begin
            errors++; $display("FAIL nonoverlap_cnt: got %0d expected %0d", match_cnt, CNT_EN ? 1 : 0);
        end
        tick();
        overlap_en = 1'b1;
    endtask

    task automatic test_gap();
        logic [6:0] sd = 7'b1010111;
        logic [6:0] sv = 7'b1100011;
        logic [6:0] se = 7'b0000001;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            apply(sd[i], sv[i]);
            checks++;
            if (d_out !== se[i]) begin
                errors++; $display("FAIL gap step%0d: d_out %b expected %b", 7 - i, d_out, se[i]);
            end
            tick();
        end
    endtask

    task automatic load_pattern(input logic [3:0] p, input logic d, input logic v);
        @(negedge clk);
        pat_load = 1'b1; pat_in = p; d_in = d; d_valid = v; cnt_clr = 1'b0;
        #1;
        checks++;
        if (d_out !== 1'b0) begin
            errors++; $display("FAIL load_dout: d_out %b expected 0", d_out);
        end
        tick();
    endtask

    task automatic test_pat_load();
        logic [3:0] s1 = 4'b1011;
        logic [3:0] s2 = 4'b1101;
        logic [2:0] s3 = 3'b110;
        do_reset();
        load_pattern(4'b1101, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            apply(s1[i], 1'b1);
            checks++;
            if (d_out !== 1'b0) begin
                errors++; $display("FAIL newpat_old bit%0d: d_out %b expected 0", 4 - i, d_out);
            end
            tick();
        end
        for (int i = 3; i >= 0; i--) begin
            apply(s2[i], 1'b1);
            checks++;
            if (d_out !== (i == 0)) begin
                errors++; $display("FAIL newpat_new bit%0d: d_out %b expected %b", 4 - i, d_out, i == 0);
            end
            tick();
        end
        for (int i = 2; i >= 0; i--) begin
            apply(s3[i], 1'b1); tick();
        end
        // The would-be final bit arrives with pat_load and must be dropped.
        load_pattern(4'b1101, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            apply(s2[i], 1'b1);
            checks++;
            if (d_out !== (i == 0)) begin
                errors++; $display("FAIL load_drop bit%0d: d_out %b expected %b", 4 - i, d_out, i == 0);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] pre  = 3'b101;
        logic [3:0] post = 4'b1011;
        for (int i = 2; i >= 0; i--) begin
            apply(pre[i], 1'b1); tick();
        end
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            apply(post[i], 1'b1);
            checks++;
            if (d_out !== (i == 0)) begin
                errors++; $display("FAIL reset_mid bit%0d: d_out %b expected %b", 4 - i, d_out, i == 0);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        logic [15:0] s = 16'b1011011011011011;
        int pulses = 0;
        do_reset();
        overlap_en = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            apply(s[i], 1'b1);
            if (d_out === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 5) begin
            errors++; $display("FAIL sat_pulses: got %0d expected 5", pulses);
        end
        apply(1'b0, 1'b0);
        checks++;
        if (match_cnt !== (CNT_EN ? 2'd3 : 2'd0)) begin
            errors++; $display("FAIL sat_cnt: got %0d expected %0d", match_cnt, CNT_EN ? 3 : 0);
        end
        tick();
        apply(1'b0, 1'b1); tick();
        apply(1'b1, 1'b1); tick();
        apply(1'b1, 1'b1);
        cnt_clr = 1'b1;
        #1;
        checks++;
        if (d_out !== 1'b1) begin
            errors++; $display("FAIL clr_match_dout: got %b expected 1", d_out);
        end
        tick();
        apply(1'b0, 1'b0);
        checks++;
        if (match_cnt !== 2'd0) begin
            errors++; $display("FAIL clr_cnt: got %0d expected 0", match_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            d_in       = 1'($urandom_range(0, 1));
            d_valid    = ($urandom_range(0, 3) != 0);
            overlap_en = ($urandom_range(0, 7) != 0) ? overlap_en : ~overlap_en;
            pat_load   = ($urandom_range(0, 39) == 0);
            pat_in     = 4'($urandom_range(0, 15));
            cnt_clr    = ($urandom_range(0, 29) == 0);
            #1;
            checks++;
            if (d_out !== model_dout()) begin
                errors++; $display("FAIL rand_dout cyc%0d: got %b expected %b", i, d_out, model_dout());
            end
            checks++;
            if (match_cnt !== model_cnt()) begin
                errors++; $display("FAIL rand_cnt cyc%0d: got %0d expected %0d", i, match_cnt, model_cnt());
            end
            tick();
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gap();
        test_pat_load();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_detector_param
`default_nettype wire
